gnn_layer_sched: RTL and testbench

Scheduler that sequences the shared dot-product datapath of the 4-node, 2-layer GNN engine. On `start` it issues 16 layer-0 operations (4 nodes × 4 hidden neurons), waits on a barrier until every layer-0 result is written back, issues 8 layer-1 operations (4 nodes × 2 outputs), drains, and pulses `done`. It tracks outstanding operations in a tag FIFO so that pipelined results are steered to the correct hidden/output register. It sits between the top-level `in_ready` handshake and the MAC/aggregation datapath.

---
 rtl/gnn_pkg.sv | 32 +++
 rtl/gnn_tag_fifo.sv | 67 ++++++
 rtl/gnn_layer_sched.sv | 167 ++++++++++++++++
 tb/tb_gnn_layer_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gnn_pkg
// Description : Shared types and constants for the GNN layer scheduler.
//               - gnn_tag_t   : {layer, node, neuron} tag of an in-flight op
//               - gnn_state_t : scheduler state encoding (c_ST_* constants)
//               - N_NODES / N_HID / N_OUT : engine geometry
// Revision    : 1.0 - initial release
// ============================================================================
package gnn_pkg;

    localparam int N_NODES = 4;
    localparam int N_HID   = 4;
    localparam int N_OUT   = 2;

    typedef struct packed {
        logic       layer;
        logic [1:0] node;
        logic [1:0] neuron;
    } gnn_tag_t;

    typedef logic [2:0] gnn_state_t;

    localparam gnn_state_t c_ST_IDLE  = 3'd0;
    localparam gnn_state_t c_ST_L0    = 3'd1;
    localparam gnn_state_t c_ST_BAR   = 3'd2;
    localparam gnn_state_t c_ST_L1    = 3'd3;
    localparam gnn_state_t c_ST_DRAIN = 3'd4;
    localparam gnn_state_t c_ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/gnn_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gnn_tag_fifo
// Description : Synchronous FIFO of gnn_tag_t holding the tags of operations
//               issued to the datapath but not yet returned.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   head       : oldest tag
//   count      : current occupancy, full, empty : status flags
// Revision    : 1.0 - initial release
// ============================================================================
module gnn_tag_fifo
    import gnn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  gnn_tag_t                 din,
    input  logic                     pop,
    output gnn_tag_t                 head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_AW = $clog2(DEPTH);

    gnn_tag_t        r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign full   = (r_count == (c_AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gnn_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : gnn_layer_sched
// Description : Sequences the shared dot-product datapath of the 4-node,
//               2-layer GNN engine: 16 layer-0 ops, barrier, 8 layer-1 ops,
//               drain, done pulse. Outstanding op tags are held in a FIFO so
//               returning results are steered to the right register.
//   start / busy / done             : run control and status
//   issue_valid, stall, issue_*     : op issue to datapath (decoded)
//   res_valid                       : in-order result return
//   wb_en, wb_*                     : registered write-back strobe and tag
//   node_ready                      : per-node sticky "outputs complete"
//   err                             : sticky result-without-tag error
// Revision    : 1.0 - initial release
// ============================================================================
module gnn_layer_sched
    import gnn_pkg::*;
#(
    parameter int TAG_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       issue_valid,
    input  logic       stall,
    output logic       issue_layer,
    output logic [1:0] issue_node,
    output logic [1:0] issue_neuron,
    input  logic       res_valid,
    output logic       wb_en,
    output logic       wb_layer,
    output logic [1:0] wb_node,
    output logic [1:0] wb_neuron,
    output logic [3:0] node_ready,
    output logic       err
);

    localparam int c_CW = $clog2(TAG_DEPTH) + 1;

    gnn_state_t  r_state;
    gnn_state_t  w_state_nxt;
    logic [1:0]  r_node;
    logic [1:0]  r_neuron;
    logic        r_busy;
    logic        r_done;
    logic        r_wb_en;
    gnn_tag_t    r_wb_tag;
    logic [3:0]  r_node_ready;
    logic        r_err;

    logic [c_CW-1:0] w_count;
    logic        w_full;
    logic        w_empty;
    gnn_tag_t    w_head;
    gnn_tag_t    w_issue_tag;
    logic        w_in_issue;
    logic        w_accept;
    logic        w_neuron_last;
    logic        w_node_last;
    logic        w_last_issue;
    logic        w_pop;
    logic        w_run_start;

    assign w_in_issue    = (r_state == c_ST_L0) || (r_state == c_ST_L1);
    // Full check uses the registered count only; a same-cycle pop does not
    // free a slot until the following cycle.
    assign issue_valid   = w_in_issue && !w_full;
    assign w_accept      = issue_valid && !stall;
    assign w_neuron_last = (r_state == c_ST_L1) ? (r_neuron == 2'(N_OUT - 1))
                                                : (r_neuron == 2'(N_HID - 1));
    assign w_node_last   = (r_node == 2'(N_NODES - 1));
    assign w_last_issue  = w_accept && w_neuron_last && w_node_last;
    assign w_pop         = res_valid && !w_empty;
    assign w_run_start   = (r_state == c_ST_IDLE) && start;

    assign w_issue_tag.layer  = (r_state == c_ST_L1);
    assign w_issue_tag.node   = r_node;
    assign w_issue_tag.neuron = r_neuron;

    assign issue_layer  = w_issue_tag.layer;
    assign issue_node   = w_issue_tag.node;
    assign issue_neuron = w_issue_tag.neuron;

    gnn_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .din   (w_issue_tag),
        .pop   (w_pop),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start)            w_state_nxt = c_ST_L0;
            c_ST_L0:    if (w_last_issue)     w_state_nxt = c_ST_BAR;
            c_ST_BAR:   if (w_count == '0)    w_state_nxt = c_ST_L1;
            c_ST_L1:    if (w_last_issue)     w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_count == '0)    w_state_nxt = c_ST_DONE;
            c_ST_DONE:                        w_state_nxt = c_ST_IDLE;
            default:                          w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_node       <= '0;
            r_neuron     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wb_en      <= 1'b0;
            r_wb_tag     <= '0;
            r_node_ready <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_ST_IDLE);
            r_done  <= (w_state_nxt == c_ST_DONE);

            // Counters wrap to zero after the last L0 op, ready for L1.
            if (w_run_start) begin
                r_node   <= '0;
                r_neuron <= '0;
            end else if (w_accept) begin
                if (w_neuron_last) begin
                    r_neuron <= '0;
                    r_node   <= r_node + 1'b1;
                end else begin
                    r_neuron <= r_neuron + 1'b1;
                end
            end

            r_wb_en <= w_pop;
            if (w_pop) r_wb_tag <= w_head;

            if (w_run_start) begin
                r_err        <= 1'b0;
                r_node_ready <= '0;
            end else begin
                if (res_valid && w_empty) r_err <= 1'b1;
                // Last layer-1 output of a node completes that node.
                if (w_pop && w_head.layer && (w_head.neuron == 2'(N_OUT - 1)))
                    r_node_ready[w_head.node] <= 1'b1;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign wb_en      = r_wb_en;
    assign wb_layer   = r_wb_tag.layer;
    assign wb_node    = r_wb_tag.node;
    assign wb_neuron  = r_wb_tag.neuron;
    assign node_ready = r_node_ready;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gnn_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gnn_layer_sched
// Description : Directed self-checking bench for gnn_layer_sched. A cycle
//               loop drives start/stall and an in-order responder with
//               configurable latency, then checks issue order, write-back
//               order, timing landmarks, done count and sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gnn_layer_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       res_valid;
    logic       busy;
    logic       done;
    logic       issue_valid;
    logic       issue_layer;
    logic [1:0] issue_node;
    logic [1:0] issue_neuron;
    logic       wb_en;
    logic       wb_layer;
    logic [1:0] wb_node;
    logic [1:0] wb_neuron;
    logic [3:0] node_ready;
    logic       err;

    int total = 0;
    int bad   = 0;

    int g_first_acc;
    int g_first_l1;
    int g_last_wb;
    int g_l0_last_wb;
    int g_done_cyc;
    bit g_saw_full;

    always #5 clk = ~clk;

    gnn_layer_sched #(
        .TAG_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .issue_valid  (issue_valid),
        .stall        (stall),
        .issue_layer  (issue_layer),
        .issue_node   (issue_node),
        .issue_neuron (issue_neuron),
        .res_valid    (res_valid),
        .wb_en        (wb_en),
        .wb_layer     (wb_layer),
        .wb_node      (wb_node),
        .wb_neuron    (wb_neuron),
        .node_ready   (node_ready),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected tag {layer,node,neuron} of the i-th op of a run.
    function automatic logic [4:0] exp_tag_of(input int i);
        if (i < 16)      return {1'b0, 2'(i / 4), 2'(i % 4)};
        else if (i < 24) return {1'b1, 2'((i - 16) / 2), 2'((i - 16) % 2)};
        else             return 5'h1f;
    endfunction

    // One complete run. Cycle 0 is the cycle in which start is driven high.
    task automatic run_sched(input int lat, input int st_lo, input int st_hi,
                             input int late_idx, input int late_extra,
                             input bit pulse_start, input string nm);
        int due[$];
        int n_acc, n_wb, n_done, outst;
        bit order_ok, wb_ok, iv_ok, hold_ok, prev_held;
        logic [4:0] prev_tag, cur_tag;
        n_acc = 0; n_wb = 0; n_done = 0; outst = 0;
        order_ok = 1; wb_ok = 1; iv_ok = 1; hold_ok = 1; prev_held = 0;
        prev_tag = '0;
        g_first_acc = -1; g_first_l1 = -1; g_last_wb = -1;
        g_l0_last_wb = -1; g_done_cyc = -1; g_saw_full = 0;
        @(posedge clk); #1;
        for (int t = 0; t < 400; t++) begin
            start     = (t == 0) || (pulse_start && (t == 5 || t == 29));
            stall     = (t >= st_lo) && (t <= st_hi);
            res_valid = 1'b0;
            if (due.size() > 0 && due[0] == t) begin
                res_valid = 1'b1;
                void'(due.pop_front());
            end
            @(negedge clk);
            cur_tag = {issue_layer, issue_node, issue_neuron};
            if (outst >= 4 && issue_valid) iv_ok = 0;
            if (outst >= 4 && !issue_valid) g_saw_full = 1;
            if (prev_held && (!issue_valid || cur_tag !== prev_tag)) hold_ok = 0;
            prev_held = issue_valid && stall;
            prev_tag  = cur_tag;
            if (issue_valid && !stall) begin
                if (cur_tag !== exp_tag_of(n_acc)) order_ok = 0;
                if (n_acc == 0)  g_first_acc = t;
                if (n_acc == 16) g_first_l1 = t;
                due.push_back(t + lat + ((n_acc == late_idx) ? late_extra : 0));
                n_acc++;
                outst++;
            end
            if (wb_en) begin
                if ({wb_layer, wb_node, wb_neuron} !== exp_tag_of(n_wb)) wb_ok = 0;
                if (n_wb == 15) g_l0_last_wb = t;
                n_wb++;
                g_last_wb = t;
            end
            if (res_valid && outst > 0) outst--;
            if (done) begin
                n_done++;
                g_done_cyc = t;
            end
            if (n_done > 0 && t > g_done_cyc + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0; res_valid = 1'b0;
        chk({nm, "_n_issue"},    n_acc,      24);
        chk({nm, "_n_wb"},       n_wb,       24);
        chk({nm, "_issue_order"}, order_ok,  1);
        chk({nm, "_wb_order"},   wb_ok,      1);
        chk({nm, "_n_done"},     n_done,     1);
        chk({nm, "_full_gate"},  iv_ok,      1);
        chk({nm, "_stall_hold"}, hold_ok,    1);
        chk({nm, "_node_ready"}, node_ready, 4'hf);
        chk({nm, "_err"},        err,        0);
        chk({nm, "_busy_end"},   busy,       0);
        chk({nm, "_barrier"},    (g_first_l1 > g_l0_last_wb) ? 1 : 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; res_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_iv",    issue_valid, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_err",   err, 0);
        chk("rst_nready", node_ready, 0);
        chk("rst_itag",  {issue_layer, issue_node, issue_neuron}, 0);
        chk("rst_wtag",  {wb_layer, wb_node, wb_neuron}, 0);
        rst_n = 1'b1;

        // Nominal: latency 2, no stall.
        run_sched(2, -1, -1, -1, 0, 1'b0, "nom");
        chk("nom_first_issue", g_first_acc, 1);
        chk("nom_first_l1",    g_first_l1, 20);
        chk("nom_last_wb",     g_last_wb, 30);
        chk("nom_done_cyc",    g_done_cyc, 31);

        // Backpressure: stall in cycles 3..5.
        run_sched(2, 3, 5, -1, 0, 1'b0, "bp");
        chk("bp_done_cyc", g_done_cyc, 34);

        // Slow responder: FIFO must fill.
        run_sched(8, -1, -1, -1, 0, 1'b0, "slow");
        chk("slow_saw_full", g_saw_full, 1);

        // Barrier: final L0 result delayed by 10 cycles.
        run_sched(2, -1, -1, 15, 10, 1'b0, "bar");
        chk("bar_l0_last_wb", g_l0_last_wb, 29);
        chk("bar_first_l1",   g_first_l1, 30);

        // Stray result while idle.
        @(posedge clk); #1 res_valid = 1'b1;
        @(negedge clk);
        chk("idle_res_wb_en0", wb_en, 0);
        @(posedge clk); #1 res_valid = 1'b0;
        @(negedge clk);
        chk("idle_res_err",    err, 1);
        chk("idle_res_wb_en1", wb_en, 0);

        // Reset in the middle of a run (responder silent, FIFO fills).
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy",   busy, 0);
        chk("mid_rst_iv",     issue_valid, 0);
        chk("mid_rst_done",   done, 0);
        chk("mid_rst_wb_en",  wb_en, 0);
        chk("mid_rst_err",    err, 0);
        chk("mid_rst_nready", node_ready, 0);
        chk("mid_rst_itag",   {issue_layer, issue_node, issue_neuron}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 res_valid = 1'b1;
        @(posedge clk); #1 res_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_stray_err", err, 1);
        chk("post_rst_wb_en",     wb_en, 0);

        // Fresh run after reset, with start pulses in L0 and DRAIN.
        run_sched(2, -1, -1, -1, 0, 1'b1, "pulse");
        chk("pulse_done_cyc", g_done_cyc, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
